// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and iterative ALU state encoding
//
// Purpose: operation codes produced by the ALU control decoder and the
// state enum of the alu_iter sequencer.
// Ports: none (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_div_unit.sv
// rtl/alu_div_unit.sv - unsigned restoring divider datapath, one quotient bit per step
//
// Purpose: holds partial remainder, shifting dividend/quotient and divisor.
// The controlling FSM pulses load_i once, then step_i once per quotient bit.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i            capture dividend_i/divisor_i, clear remainder
//   step_i            perform one subtract-and-shift iteration
//   dividend_i        dividend (WIDTH)
//   divisor_i         divisor (WIDTH, nonzero when used)
//   quot_next_o       quotient value after the current step (WIDTH)
//   rem_next_o        remainder value after the current step (WIDTH)
module alu_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the remainder and try subtracting.
  // The partial remainder is always below the divisor, so a set top bit of
  // the (WIDTH+1)-bit difference means the subtraction borrowed.
  assign trial       = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
  assign rem_next_o  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quot_next_o = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_next_o;
      quot_q <= quot_next_o;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle ALU with iterative multiply and divide
//
// Purpose: single-cycle add/sub/and/or/slt/nop, shift-add multiply and
// restoring divide behind a start/busy/done handshake.
// Optional feature macro: ALU_ITER_EARLY_OUT_EN (multiply stops once the
// remaining multiplier bits are all zero).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           request, sampled when not busy
//   op_i              3-bit op code (alu_pkg OP_*)
//   a_i, b_i          operands (WIDTH)
//   result_o, hi_o    low result / quotient, high product / remainder
//   zero_o            result_o == 0
//   busy_o            iterative op in progress
//   done_o            one-cycle completion pulse
//   div_by_zero_o     last divide had b_i == 0
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
  logic               zero_q, zero_d, dbz_q, dbz_d;

  logic               div_load, div_step;
  logic [WIDTH-1:0]   quot_next, rem_next;

  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   mplier_step;
  logic               mul_last;

  alu_div_unit #(.WIDTH(WIDTH)) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (a_i),
    .divisor_i   (b_i),
    .quot_next_o (quot_next),
    .rem_next_o  (rem_next)
  );

  // Multiplicand shifts left and the multiplier right, so the product is
  // aligned after any iteration and the loop may stop early.
  assign prod_step   = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mplier_step = mplier_q >> 1;

`ifdef ALU_ITER_EARLY_OUT_EN
  assign mul_last = (cnt_q == LAST) || (mplier_step == '0);
`else
  assign mul_last = (cnt_q == LAST);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    div_load = 1'b0;
    div_step = 1'b0;

    case (state_q)
      // A request is accepted in the DONE cycle too, so single-cycle ops
      // can complete back-to-back.
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start_i) begin
          cnt_d   = '0;
          state_d = ST_FIN;
          dbz_d   = 1'b0;
          hi_d    = '0;
          case (op_i)
            OP_ADD: result_d = a_i + b_i;
            OP_SUB: result_d = a_i - b_i;
            OP_AND: result_d = a_i & b_i;
            OP_OR:  result_d = a_i | b_i;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_MUL: begin
              hi_d     = hi_q;
              prod_d   = '0;
              mcand_d  = {{WIDTH{1'b0}}, a_i};
              mplier_d = b_i;
              state_d  = ST_MUL;
            end
            OP_DIV: begin
              if (b_i == '0) begin
                result_d = '1;
                hi_d     = a_i;
                dbz_d    = 1'b1;
              end else begin
                hi_d     = hi_q;
                div_load = 1'b1;
                state_d  = ST_DIV;
              end
            end
            default: hi_d = hi_q;
          endcase
        end
      end
      ST_MUL: begin
        prod_d   = prod_step;
        mplier_d = mplier_step;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (mul_last) begin
          result_d = prod_step[WIDTH-1:0];
          hi_d     = prod_step[2*WIDTH-1:WIDTH];
          dbz_d    = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = quot_next;
          hi_d     = rem_next;
          dbz_d    = 1'b0;
          state_d  = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_o      = result_q;
  assign hi_o          = hi_q;
  assign zero_o        = zero_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done_o        = (state_q == ST_FIN);

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed self-checking bench for alu_iter
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, result, hi;
  logic         zero, busy, done, dbz;

  int n_checks = 0;
  int n_errors = 0;
  int lat, nbusy, ndone;

`ifdef ALU_ITER_EARLY_OUT_EN
  localparam int MUL4_LAT = 4;
  localparam int MUL4_BSY = 3;
  localparam int MUL16_LAT = 6;
`else
  localparam int MUL4_LAT = 33;
  localparam int MUL4_BSY = 32;
  localparam int MUL16_LAT = 33;
`endif

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .result_o      (result),
    .hi_o          (hi),
    .zero_o        (zero),
    .busy_o        (busy),
    .done_o        (done),
    .div_by_zero_o (dbz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, then wait for DONE.
  // lat counts cycles after the accepting edge (1 = the cycle right after).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l, output int nb);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_SUB; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A;
    l  = 1;
    nb = 0;
    while (!done && l < 100) begin
      if (busy) nb++;
      @(negedge clk);
      l++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_with_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, dbz}, 64'd0);
    rst = 1'b0;

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, lat, nbusy);
    check("add_lat", 64'(lat), 64'd1);
    check("add_busy", 64'(nbusy), 64'd0);
    check("add_result", {32'd0, result}, 64'd0);
    check("add_zero", {63'd0, zero}, 64'd1);
    check("add_hi", {32'd0, hi}, 64'd0);

    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, nbusy);
    check("slt_result", {32'd0, result}, 64'd1);
    check("slt_zero", {63'd0, zero}, 64'd0);

    run_op(OP_SUB, 32'd5, 32'd7, lat, nbusy);
    check("sub_result", {32'd0, result}, 64'hFFFF_FFFE);

    run_op(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, lat, nbusy);
    check("and_result", {32'd0, result}, 64'h0000_F000);

    run_op(OP_MUL, 32'h8000_0000, 32'd4, lat, nbusy);
    check("mul4_lat", 64'(lat), 64'(MUL4_LAT));
    check("mul4_busy", 64'(nbusy), 64'(MUL4_BSY));
    check("mul4_hi", {32'd0, hi}, 64'd2);
    check("mul4_result", {32'd0, result}, 64'd0);
    check("mul4_zero", {63'd0, zero}, 64'd1);

    run_op(OP_MUL, 32'h1234_5678, 32'h10, lat, nbusy);
    check("mul16_lat", 64'(lat), 64'(MUL16_LAT));
    check("mul16_prod", {hi, result}, 64'h1_2345_6780);

    run_op(OP_DIV, 32'd100, 32'd7, lat, nbusy);
    check("div_lat", 64'(lat), 64'd33);
    check("div_busy", 64'(nbusy), 64'd32);
    check("div_result", {32'd0, result}, 64'd14);
    check("div_hi", {32'd0, hi}, 64'd2);
    check("div_dbz", {63'd0, dbz}, 64'd0);

    run_op(OP_DIV, 32'd9, 32'd0, lat, nbusy);
    check("dbz_lat", 64'(lat), 64'd1);
    check("dbz_result", {32'd0, result}, 64'hFFFF_FFFF);
    check("dbz_hi", {32'd0, hi}, 64'd9);
    check("dbz_flag", {63'd0, dbz}, 64'd1);

    run_op(OP_NOP, 32'd0, 32'd0, lat, nbusy);
    check("nop_lat", 64'(lat), 64'd1);
    check("nop_result", {32'd0, result}, 64'hFFFF_FFFF);
    check("nop_hi", {32'd0, hi}, 64'd9);
    check("nop_dbz", {63'd0, dbz}, 64'd0);

    // START pulses while a multiply is busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5;
    @(negedge clk);
    ndone = 0;
    for (int i = 0; i < W + 10; i++) begin
      if (done) ndone++;
      start = busy;
      op = OP_ADD; a = 32'd1; b = 32'd1;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_dones", 64'(ndone), 64'd1);
    check("busy_start_result", {hi, result}, 64'd15);

    // Back-to-back single-cycle ops.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'd3; b = 32'd4;
    @(negedge clk);
    check("b2b_done1", {63'd0, done}, 64'd1);
    check("b2b_result1", {32'd0, result}, 64'd7);
    op = OP_OR; a = 32'hF0; b = 32'h0F;
    @(negedge clk);
    check("b2b_done2", {63'd0, done}, 64'd1);
    check("b2b_result2", {32'd0, result}, 64'hFF);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done3", {63'd0, done}, 64'd0);
    check("hold_result", {32'd0, result}, 64'hFF);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_result", {32'd0, result}, 64'd0);
    check("mrst_hi", {32'd0, hi}, 64'd0);
    check("mrst_zero", {63'd0, zero}, 64'd1);
    check("mrst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", 64'(ndone), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
